// File: rtl/ps2_key_pkg.sv
// Shared types and constants for the PS/2 key tracker: receiver states,
// scancode prefixes and the 32-entry scancode-to-bitmap table.
package ps2_key_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_STOP   = 3'd3
    } rx_state_e;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam int         NUM_KEYS = 32;

    // Index in this table is the bit position in the held-key bitmap.
    localparam logic [7:0] KEY_MAP [0:NUM_KEYS-1] = '{
        8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42,
        8'h4B, 8'h4C, 8'h52, 8'h5B, 8'h1D, 8'h24, 8'h2C, 8'h35,
        8'h3C, 8'h43, 8'h44, 8'h4D, 8'h54, 8'h15, 8'h16, 8'h1E,
        8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45
    };

    typedef struct packed {
        logic       hit;
        logic [4:0] idx;
    } key_hit_t;

    function automatic key_hit_t key_lookup(input logic [7:0] sc);
        key_hit_t r;
        r = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (!r.hit && KEY_MAP[i] == sc) begin
                r.hit = 1'b1;
                r.idx = 5'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchronisers, falling-edge detect, bit FSM and
// mid-frame timeout. Define PS2_PARITY_CHECK_EN to reject bad-parity frames.
module ps2_frame_rx
    import ps2_key_pkg::*;
#(
    parameter int TIMEOUT_CYC = 5000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic [7:0] rx_byte,
    output logic       rx_vld,
    output logic       frame_err,
    output logic [2:0] state_dbg
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_s;
    logic                   dat_s;
    logic                   clk_prev;
    logic                   fall;

    rx_state_e              state;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;
    logic [CNT_W-1:0]       to_cnt;
`ifdef PS2_PARITY_CHECK_EN
    logic                   par_bit;
`endif

    // Idle-high lines, so synchronisers come out of reset at 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync[0] <= i_ps2_clk;
            dat_sync[0] <= i_ps2_dat;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_sync[i] <= clk_sync[i-1];
                dat_sync[i] <= dat_sync[i-1];
            end
        end
    end

    assign clk_s     = clk_sync[SYNC_STAGES-1];
    assign dat_s     = dat_sync[SYNC_STAGES-1];
    assign fall      = clk_prev & ~clk_s;
    assign state_dbg = state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_prev  <= 1'b1;
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            to_cnt    <= '0;
            rx_byte   <= '0;
            rx_vld    <= 1'b0;
            frame_err <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            clk_prev  <= clk_s;
            rx_vld    <= 1'b0;
            frame_err <= 1'b0;

            if (fall)
                to_cnt <= '0;
            else if (state != S_IDLE)
                to_cnt <= to_cnt + 1'b1;

            if (fall) begin
                case (state)
                    S_IDLE: begin
                        if (!dat_s) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        shreg   <= {dat_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= S_PARITY;
                    end
                    S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        par_bit <= dat_s;
`endif
                        state   <= S_STOP;
                    end
                    S_STOP: begin
                        state <= S_IDLE;
                        if (!dat_s) begin
                            frame_err <= 1'b1;
                        end else begin
`ifdef PS2_PARITY_CHECK_EN
                            // Odd parity: data plus parity bit must hold an odd count of ones.
                            if (^{shreg, par_bit}) begin
                                rx_byte <= shreg;
                                rx_vld  <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
`else
                            rx_byte <= shreg;
                            rx_vld  <= 1'b1;
`endif
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (state != S_IDLE && to_cnt == CNT_W'(TIMEOUT_CYC)) begin
                state     <= S_IDLE;
                to_cnt    <= '0;
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard held-key tracker: decodes make/break/extended scancodes into a
// 32-bit bitmap. Define PS2_PARITY_CHECK_EN to enable receiver parity checking.
module ps2_key_tracker
    import ps2_key_pkg::*;
#(
    parameter int TIMEOUT_CYC = 5000,
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ps2_clk,
    input  logic        i_ps2_dat,
    output logic [31:0] o_key,
    output logic        o_key_upd,
    output logic        o_frame_err,
    output logic [2:0]  o_state
);

    logic [7:0]  rx_byte;
    logic        rx_vld;
    logic        break_pending;
    logic        ext_pending;
    key_hit_t    hit;
    logic [31:0] key_nxt;

    ps2_frame_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_ps2_clk (i_ps2_clk),
        .i_ps2_dat (i_ps2_dat),
        .rx_byte   (rx_byte),
        .rx_vld    (rx_vld),
        .frame_err (o_frame_err),
        .state_dbg (o_state)
    );

    // Extended-prefixed codes never touch the bitmap.
    always_comb begin
        hit     = key_lookup(rx_byte);
        key_nxt = o_key;
        if (hit.hit && !ext_pending)
            key_nxt[hit.idx] = ~break_pending;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_key         <= '0;
            o_key_upd     <= 1'b0;
            break_pending <= 1'b0;
            ext_pending   <= 1'b0;
        end else begin
            o_key_upd <= 1'b0;
            if (rx_vld) begin
                if (rx_byte == SC_BREAK) begin
                    break_pending <= 1'b1;
                end else if (rx_byte == SC_EXT) begin
                    ext_pending <= 1'b1;
                end else begin
                    o_key         <= key_nxt;
                    o_key_upd     <= (key_nxt != o_key);
                    break_pending <= 1'b0;
                    ext_pending   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: bit-banged PS/2 frames, bitmap
// updates checked against an expected-value queue.
module tb_ps2_key_tracker;

    localparam int HALF = 20;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_ps2_clk = 1'b1;
    logic        i_ps2_dat = 1'b1;
    logic [31:0] o_key;
    logic        o_key_upd;
    logic        o_frame_err;
    logic [2:0]  o_state;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int err_cnt = 0;
    int last_upd_cyc = 0;
    int fall_cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];

    ps2_key_tracker dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_ps2_clk   (i_ps2_clk),
        .i_ps2_dat   (i_ps2_dat),
        .o_key       (o_key),
        .o_key_upd   (o_key_upd),
        .o_frame_err (o_frame_err),
        .o_state     (o_state)
    );

    always #10 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (o_key_upd) begin
            obs_q.push_back(o_key);
            last_upd_cyc = cyc;
        end
        if (o_frame_err) err_cnt++;
    end

    task automatic do_reset();
        i_rst_n   = 1'b0;
        i_ps2_clk = 1'b1;
        i_ps2_dat = 1'b1;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        exp_q.delete();
        obs_q.delete();
        err_cnt = 0;
    endtask

    task automatic send_bit(input logic b);
        @(negedge i_clk);
        i_ps2_dat = b;
        repeat (HALF/2) @(negedge i_clk);
        i_ps2_clk = 1'b0;
        fall_cyc  = cyc;
        repeat (HALF) @(negedge i_clk);
        i_ps2_clk = 1'b1;
        repeat (HALF/2) @(negedge i_clk);
    endtask

    // Sends frame bits [first..last]; bit 0 start, 1-8 data, 9 parity, 10 stop.
    task automatic send_frame(input logic [7:0] b, input logic bad_par,
                              input logic bad_stop, input int first, input int last);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = first; i <= last; i++) send_bit(f[i]);
        repeat (20) @(negedge i_clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 0, 10);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        n_cmp++; if (o_key !== 32'h0) begin n_bad++; $display("FAIL reset_key: got %h want 0", o_key); end
        n_cmp++; if (o_key_upd !== 1'b0) begin n_bad++; $display("FAIL reset_upd: got %b want 0", o_key_upd); end
        n_cmp++; if (o_frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", o_frame_err); end
        n_cmp++; if (o_state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", o_state); end
        do_reset();
    endtask

    task automatic test_single();
        logic [31:0] e, o;
        do_reset();
        exp_q.push_back(32'h1);
        send_good(8'h1C);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL single_cnt: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL single_key: got %h want %h", o, e); end
        end
        n_cmp++; if (last_upd_cyc - fall_cyc !== 4) begin n_bad++; $display("FAIL single_latency: got %0d want 4", last_upd_cyc - fall_cyc); end
    endtask

    task automatic test_sequence();
        logic [31:0] e, o;
        do_reset();
        exp_q.push_back(32'h1); send_good(8'h1C);
        exp_q.push_back(32'h3); send_good(8'h1B);
        send_good(8'hF0);
        exp_q.push_back(32'h2); send_good(8'h1C);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL seq_cnt: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL seq_key: got %h want %h", o, e); end
        end
    endtask

    task automatic test_ext_and_repeat();
        logic [31:0] e, o;
        do_reset();
        send_good(8'hE0);
        send_good(8'h1C);
        n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL ext_no_upd: got %0d pulses want 0", obs_q.size()); end
        n_cmp++; if (o_key !== 32'h0) begin n_bad++; $display("FAIL ext_key: got %h want 0", o_key); end
        exp_q.push_back(32'h1); send_good(8'h1C);
        send_good(8'h1C);
        send_good(8'h77);
        exp_q.push_back(32'h5); send_good(8'h23);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL repeat_cnt: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL repeat_key: got %h want %h", o, e); end
        end
    endtask

    task automatic test_errors();
        do_reset();
        send_frame(8'h1C, 1'b1, 1'b0, 0, 10);
`ifdef PS2_PARITY_CHECK_EN
        n_cmp++; if (err_cnt !== 1) begin n_bad++; $display("FAIL parity_err: got %0d want 1", err_cnt); end
        n_cmp++; if (o_key !== 32'h0) begin n_bad++; $display("FAIL parity_key: got %h want 0", o_key); end
`else
        n_cmp++; if (err_cnt !== 0) begin n_bad++; $display("FAIL parity_err: got %0d want 0", err_cnt); end
        n_cmp++; if (o_key !== 32'h1) begin n_bad++; $display("FAIL parity_key: got %h want 1", o_key); end
`endif
        do_reset();
        send_good(8'hF0);
        send_frame(8'h1B, 1'b0, 1'b1, 0, 10);
        n_cmp++; if (err_cnt !== 1) begin n_bad++; $display("FAIL stop_err: got %0d want 1", err_cnt); end
        // Break prefix must survive the error, so this 1B is a release.
        send_good(8'h1B);
        n_cmp++; if (obs_q.size() !== 0 || o_key !== 32'h0) begin n_bad++; $display("FAIL stop_keep_break: got %h/%0d want 0/0", o_key, obs_q.size()); end
    endtask

    task automatic test_timeout();
        logic [31:0] e, o;
        do_reset();
        send_frame(8'h1C, 1'b0, 1'b0, 0, 4);
        repeat (6000) @(negedge i_clk);
        n_cmp++; if (err_cnt !== 1) begin n_bad++; $display("FAIL timeout_err: got %0d want 1", err_cnt); end
        n_cmp++; if (o_state !== 3'd0) begin n_bad++; $display("FAIL timeout_state: got %0d want 0", o_state); end
        exp_q.push_back(32'h4); send_good(8'h23);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL timeout_cnt: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL timeout_key: got %h want %h", o, e); end
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] e, o;
        do_reset();
        send_good(8'h1C);
        n_cmp++; if (o_key !== 32'h1) begin n_bad++; $display("FAIL midrst_pre: got %h want 1", o_key); end
        send_frame(8'h1B, 1'b0, 1'b0, 0, 4);
        i_rst_n = 1'b0;
        #1;
        n_cmp++; if (o_key !== 32'h0) begin n_bad++; $display("FAIL midrst_key: got %h want 0", o_key); end
        n_cmp++; if (o_state !== 3'd0) begin n_bad++; $display("FAIL midrst_state: got %0d want 0", o_state); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        obs_q.delete();
        err_cnt = 0;
        send_frame(8'h1B, 1'b0, 1'b0, 5, 10);
        repeat (6000) @(negedge i_clk);
        n_cmp++; if (err_cnt > 1 || obs_q.size() !== 0) begin n_bad++; $display("FAIL midrst_tail: got %0d errs/%0d upd want <=1/0", err_cnt, obs_q.size()); end
        exp_q.push_back(32'h2); send_good(8'h1B);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL midrst_cnt: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL midrst_key2: got %h want %h", o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sequence();
        test_ext_and_repeat();
        test_errors();
        test_timeout();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
